// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer placed directly after a UART receiver. Each byte the
// receiver flags on rx_rdy is captured once, acknowledged on rx_rdy_clr, and
// stored in a first-word-fall-through FIFO that host logic drains with a
// valid/ready handshake.
//
// Optional feature macro: UART_RX_FIFO_OVERRUN_EN
//   When defined, bytes dropped because the FIFO is full set the sticky
//   overrun flag and bump the saturating drop_cnt. ovr_clr clears both.
//   When undefined, overrun and drop_cnt are tied 0 and ovr_clr is ignored.
//
// Parameters
//   DEPTH_LOG2   FIFO depth is 2**DEPTH_LOG2 entries (legal range 1..8).
//
// Ports
//   clk_50m      in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   rx_rdy       in   receiver byte-ready level (held until cleared)
//   rx_data      in   receiver byte, valid while rx_rdy is high
//   rx_rdy_clr   out  registered ready-clear back to the receiver
//   rd_valid     out  FIFO not empty
//   rd_data      out  head byte (meaningful while rd_valid is high)
//   rd_ready     in   consumer accepts the head byte
//   count        out  number of stored bytes, 0..2**DEPTH_LOG2
//   full         out  count == 2**DEPTH_LOG2
//   empty        out  count == 0
//   overrun      out  sticky drop flag
//   drop_cnt     out  saturating dropped-byte count
//   ovr_clr      in   clears overrun and drop_cnt
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  rx_rdy,
  input  logic [7:0]            rx_data,
  output logic                  rx_rdy_clr,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic [7:0]            drop_cnt,
  input  logic                  ovr_clr
);

  localparam int unsigned           DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_rdy_clr_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  push_attempt;
  logic                  push;
  logic                  pop;

  // ---------------------------------------------------------------------------
  // Capture FSM: one push attempt per rx_rdy assertion, then hold the
  // acknowledge until the receiver lets rx_rdy fall.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and infers a latch.
    state_d      = state_q;
    push_attempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_rdy) begin
          push_attempt = 1'b1;
          state_d      = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!rx_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      rx_rdy_clr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Registered copy of "next state is ACK": high for every cycle in ACK.
      rx_rdy_clr_q <= (state_d == ST_ACK);
    end
  end

  assign rx_rdy_clr = rx_rdy_clr_q;

  // ---------------------------------------------------------------------------
  // FIFO pointers and status. The extra pointer bit distinguishes full from
  // empty when the indices coincide.
  // ---------------------------------------------------------------------------
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_valid = !empty;

  assign pop  = rd_valid && rd_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly the slot
  // wr_ptr indexes, so the new byte lands there.
  assign push = push_attempt && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries
  // are live, so stale contents are never observable.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_data;
    end
  end

  // First-word-fall-through: the head is always presented combinationally.
  assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // ---------------------------------------------------------------------------
  // Overrun reporting
  // ---------------------------------------------------------------------------
`ifdef UART_RX_FIFO_OVERRUN_EN
  logic       drop;
  logic       overrun_q;
  logic [7:0] drop_cnt_q;

  assign drop = push_attempt && !push;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else if (drop) begin
      // A drop in the same cycle as ovr_clr wins: the clear is applied first
      // and this drop is then counted as the first one.
      overrun_q <= 1'b1;
      if (ovr_clr) begin
        drop_cnt_q <= 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end else if (ovr_clr) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_ovr_clr;

  assign unused_ovr_clr = ovr_clr;
  assign overrun        = 1'b0;
  assign drop_cnt       = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed testbench for uart_rx_fifo (DEPTH_LOG2 = 4). Emulates the UART
// receiver's rdy/clr handshake and a host consumer, checking each observation
// against hand-derived expectations. Overrun expectations follow whether
// UART_RX_FIFO_OVERRUN_EN is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy_clr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overrun;
  logic [7:0] drop_cnt;
  logic       ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overrun    (overrun),
    .drop_cnt   (drop_cnt),
    .ovr_clr    (ovr_clr)
  );

  always #10 clk_50m = ~clk_50m;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Receiver handshake for one byte. pop_in / clr_in are applied only during
  // the capture cycle. Returns the number of cycles rx_rdy_clr was seen high.
  task automatic capture(input logic [7:0] b, input logic pop_in, input logic clr_in,
                         output int clr_cycles);
    int n;
    rx_rdy     = 1'b1;
    rx_data    = b;
    rd_ready   = pop_in;
    ovr_clr    = clr_in;
    clr_cycles = 0;
    tick();
    rd_ready = 1'b0;
    ovr_clr  = 1'b0;
    n = 0;
    while (!rx_rdy_clr && n < 8) begin
      tick();
      n++;
    end
    check("clr_seen", rx_rdy_clr, 1);
    if (rx_rdy_clr) clr_cycles++;
    tick();
    rx_rdy = 1'b0;
    if (rx_rdy_clr) clr_cycles++;
    n = 0;
    while (rx_rdy_clr && n < 8) begin
      tick();
      if (rx_rdy_clr) clr_cycles++;
      n++;
    end
    check("clr_drop", rx_rdy_clr, 0);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int cc;

    // ---------------- Reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_clr", rx_rdy_clr, 0);
    check("rst_ovr", overrun, 0);
    check("rst_drop", drop_cnt, 0);

    // ---------------- Single byte ----------------
    rx_rdy  = 1'b1;
    rx_data = 8'hA5;
    tick();                                   // cycle N+1
    check("sb_n1_count", count, 1);
    check("sb_n1_valid", rd_valid, 1);
    check("sb_n1_clr", rx_rdy_clr, 1);
    tick();                                   // cycle N+2
    rx_rdy = 1'b0;
    check("sb_n2_clr", rx_rdy_clr, 1);
    check("sb_n2_count", count, 1);           // still one push only
    tick();                                   // cycle N+3
    check("sb_n3_clr", rx_rdy_clr, 0);
    check("sb_count", count, 1);
    check("sb_data", rd_data, 8'hA5);
    pop_check("sb_pop", 8'hA5);
    check("sb_empty", empty, 1);

    // clr pulse length through the generic handshake
    capture(8'h5A, 1'b0, 1'b0, cc);
    check("clr_len", cc, 2);
    pop_check("clr_pop", 8'h5A);

    // ---------------- Ordering and wrap ----------------
    // Pointers start at 2 and end at 22, crossing the 16-entry boundary.
    for (int i = 0; i < 20; i++) begin
      capture(i[7:0], 1'b0, 1'b0, cc);
      if ((i % 4) == 3) begin
        check("wr_cnt4", count, 4);
        for (int j = i - 3; j <= i; j++) pop_check("wr_pop", j[7:0]);
      end
    end
    check("wr_empty", empty, 1);

    // ---------------- Full plus drop ----------------
    for (int i = 0; i < 17; i++) capture(8'h10 + i[7:0], 1'b0, 1'b0, cc);
    check("fd_full", full, 1);
    check("fd_count", count, 16);
    check("fd_ovr", overrun, OVR_EN ? 1 : 0);
    check("fd_drop", drop_cnt, OVR_EN ? 1 : 0);
    for (int i = 0; i < 16; i++) pop_check("fd_pop", 8'h10 + i[7:0]);
    check("fd_empty", empty, 1);              // 0x20 never stored
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("fd_clr_ovr", overrun, 0);
    check("fd_clr_drop", drop_cnt, 0);

    // ---------------- Full with simultaneous pop ----------------
    for (int i = 0; i < 16; i++) capture(8'h30 + i[7:0], 1'b0, 1'b0, cc);
    check("fp_full", full, 1);
    check("fp_head", rd_data, 8'h30);
    rx_rdy   = 1'b1;
    rx_data  = 8'h77;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("fp_count", count, 16);
    check("fp_newhead", rd_data, 8'h31);
    tick();
    rx_rdy = 1'b0;
    tick();
    check("fp_ovr", overrun, 0);
    for (int i = 1; i < 16; i++) pop_check("fp_pop", 8'h30 + i[7:0]);
    pop_check("fp_last", 8'h77);
    check("fp_empty", empty, 1);

    // ---------------- Set versus clear ----------------
    for (int i = 0; i < 16; i++) capture(8'h40 + i[7:0], 1'b0, 1'b0, cc);
    capture(8'h50, 1'b0, 1'b0, cc);
    capture(8'h51, 1'b0, 1'b0, cc);
    check("sc_drop2", drop_cnt, OVR_EN ? 2 : 0);
    capture(8'h52, 1'b0, 1'b1, cc);           // drop and ovr_clr together
    check("sc_ovr", overrun, OVR_EN ? 1 : 0);
    check("sc_drop", drop_cnt, OVR_EN ? 1 : 0);
    check("sc_count", count, 16);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("sc_clr_ovr", overrun, 0);
    check("sc_clr_drop", drop_cnt, 0);

    // ---------------- Reset mid-ACK ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_pre_empty", empty, 1);
    for (int i = 1; i <= 3; i++) capture(8'h60 + i[7:0], 1'b0, 1'b0, cc);
    check("rm_cnt3", count, 3);
    rx_rdy  = 1'b1;
    rx_data = 8'h64;
    tick();                                   // cycle N+1
    check("rm_n1_count", count, 4);
    check("rm_n1_clr", rx_rdy_clr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_count", count, 0);
    check("rm_empty", empty, 1);
    check("rm_clr", rx_rdy_clr, 0);
    check("rm_valid", rd_valid, 0);
    tick();                                   // recaptured from IDLE
    check("rm_recap_count", count, 1);
    check("rm_recap_clr", rx_rdy_clr, 1);
    check("rm_recap_data", rd_data, 8'h64);
    tick();
    rx_rdy = 1'b0;
    tick();
    check("rm_clr_end", rx_rdy_clr, 0);
    pop_check("rm_pop", 8'h64);

    // ---------------- Pop while empty ----------------
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pe_count", count, 0);
    check("pe_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It consumes each byte the receiver flags with its ready output, acknowledges it through the receiver's ready-clear input, and stores it in a first-word-fall-through FIFO. Host logic drains the FIFO with a valid/ready handshake. With the optional feature compiled in, it also reports bytes lost to a full FIFO.

## Interface
- DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16). Legal range 1..8.
- clk_50m  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- rx_rdy  input  1  receiver byte-ready level. It stays high until cleared.
- rx_data  input  8  receiver byte. Valid while rx_rdy is high.
- rx_rdy_clr  output  1  ready-clear to the receiver. Registered.
- rd_valid  output  1  FIFO not empty.
- rd_data  output  8  head byte. Meaningful only while rd_valid is high.
- rd_ready  input  1  consumer accepts the head byte.
- count  output  DEPTH_LOG2+1  number of stored bytes, from 0 to 2^DEPTH_LOG2.
- full  output  1  count == 2^DEPTH_LOG2.
- empty  output  1  count == 0.
- overrun  output  1  sticky drop flag. Tied 0 without the macro.
- drop_cnt  output  8  saturating count of dropped bytes. Tied 0 without the macro.
- ovr_clr  input  1  clears overrun and drop_cnt. Ignored without the macro.

## Operation
- Capture FSM, two states:
  - IDLE: if rx_rdy is 1, perform a push attempt with rx_data, then go to ACK.
  - ACK: rx_rdy_clr = 1 for every cycle spent in ACK. When rx_rdy is 0, go to IDLE. rx_rdy is ignored as a data strobe while in ACK, so each byte is captured exactly once.
- Push attempt: the byte is accepted if !full, or if full and a pop occurs in the same cycle. Otherwise the byte is dropped. The receiver is acknowledged either way.
- Pop: occurs when rd_valid && rd_ready. Popping while empty has no effect.
- Storage: 2^DEPTH_LOG2 x 8 array with write and read pointers of DEPTH_LOG2+1 bits.
  - Memory index is ptr[DEPTH_LOG2-1:0]. Pointers wrap naturally.
  - count = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
  - rd_data = mem[rd_ptr index], read combinationally (first-word-fall-through).
- Simultaneous push and pop:
  - Not full: both pointers advance and count is unchanged.
  - Full: the old head is popped and the new byte is written into the freed slot. count stays at full.
- Reset: state IDLE, pointers 0, rx_rdy_clr 0, count 0, empty 1, full 0, rd_valid 0, overrun 0, drop_cnt 0. Memory contents are not reset.
- Reset mid-operation: any in-progress ACK is abandoned and stored bytes are discarded. If rx_rdy is still high after reset, that byte is captured again from IDLE.

## Timing
- Cycle N: in IDLE with rx_rdy=1. The byte is written at the edge ending cycle N.
- Cycle N+1: rd_valid=1 if the FIFO was empty, count increments, and rx_rdy_clr=1.
- The receiver drops rx_rdy at the edge ending cycle N+1. The FSM sees rx_rdy=0 in cycle N+2, and rx_rdy_clr deasserts from cycle N+3.
- Minimum spacing between two captures: 3 cycles. This is far below one UART frame at any supported baud.
- Pop takes effect at the clock edge. The next head byte appears on rd_data in the following cycle.
- full, empty and count update in the cycle after the push or pop edge.

## Configuration
- Macro: UART_RX_FIFO_OVERRUN_EN.
- Defined:
  - A dropped push sets overrun and increments drop_cnt, saturating at 255.
  - ovr_clr=1 clears both at the next edge.
  - If a drop and ovr_clr occur in the same cycle, the set wins: overrun=1 and drop_cnt=1.
- Undefined: overrun and drop_cnt are constant 0, ovr_clr is unused, and drops are silent. All other behaviour is identical.

## Test plan
- Single byte: after reset, hold rx_rdy=1 with rx_data=0xA5 until rx_rdy_clr is seen, then drop it one cycle later.
  - Required: exactly one push, count=1, rd_valid=1, rd_data=0xA5, rx_rdy_clr high for 2 cycles.
- Ordering and wrap: with DEPTH_LOG2=4, push bytes 0x00..0x13 while draining after every 4th push.
  - Required: bytes pop in order 0x00..0x13, no loss, and pointers wrap past 16.
- Full plus drop: push 17 bytes 0x10..0x20 with rd_ready=0.
  - Required: full=1, count=16, and 0x20 is dropped.
  - With macro: overrun=1, drop_cnt=1.
  - Pops then return 0x10..0x1F.
- Full with simultaneous pop: with the FIFO full, hold rd_ready=1 during the capture cycle of 0x77.
  - Required: 0x77 is accepted, count stays 16, and 0x77 is the last byte popped.
- Set-versus-clear (with macro): assert ovr_clr in the same cycle as a dropped push.
  - Required: overrun=1, drop_cnt=1.
  - A further ovr_clr alone gives overrun=0, drop_cnt=0.
- Reset mid-ACK: assert rst in cycle N+1 of a capture with 3 bytes stored.
  - Required next cycle: count=0, empty=1, rx_rdy_clr=0, state IDLE.
